// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> MEMORY -> REGISTER_UPDATE,
// with halt handling, ack timeouts and a sticky trap on misaligned PC or memory timeout.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_en,
  input  logic        mem_access,
  input  logic        halt_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] pc,
  output logic [2:0]  stage,
  output logic        imem_req,
  output logic        dmem_req,
  output logic [31:0] instr,
  output logic        fault
);

  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    STAGE_FETCH           = 3'd0,
    STAGE_DECODE          = 3'd1,
    STAGE_EXECUTE         = 3'd2,
    STAGE_MEMORY          = 3'd3,
    STAGE_REGISTER_UPDATE = 3'd4,
    STAGE_HALTED          = 3'd5,
    STAGE_TRAP            = 3'd6
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic            mem_access_reg;
  logic [31:0]     pc_reg;
  logic [31:0]     instr_reg;
  logic            fault_reg;

  // Wait counter defaults to zero each cycle, so it clears on every state change
  // and only accumulates while a request is outstanding without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= STAGE_FETCH;
      wait_cnt_reg   <= '0;
      mem_access_reg <= 1'b0;
      pc_reg         <= RESET_PC;
      instr_reg      <= '0;
      fault_reg      <= 1'b0;
    end else begin
      wait_cnt_reg <= '0;
      case (state_reg)
        STAGE_FETCH: begin
          if (imem_ack) begin
            instr_reg <= imem_rdata;
            state_reg <= STAGE_DECODE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            fault_reg <= 1'b1;
            state_reg <= STAGE_TRAP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        STAGE_DECODE: state_reg <= STAGE_EXECUTE;
        STAGE_EXECUTE: begin
          mem_access_reg <= mem_access;
          state_reg      <= STAGE_MEMORY;
        end
        STAGE_MEMORY: begin
          if (!mem_access_reg || dmem_ack) begin
            state_reg <= STAGE_REGISTER_UPDATE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            fault_reg <= 1'b1;
            state_reg <= STAGE_TRAP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        STAGE_REGISTER_UPDATE: begin
          // A misaligned target traps without being loaded, ahead of any halt request.
          if (pc_en && (pc_next[1:0] != 2'b00)) begin
            fault_reg <= 1'b1;
            state_reg <= STAGE_TRAP;
          end else begin
            if (pc_en) pc_reg <= pc_next;
            state_reg <= halt_req ? STAGE_HALTED : STAGE_FETCH;
          end
        end
        STAGE_HALTED: begin
          if (!halt_req) state_reg <= STAGE_FETCH;
        end
        STAGE_TRAP: state_reg <= STAGE_TRAP;
        default: begin
          fault_reg <= 1'b1;
          state_reg <= STAGE_TRAP;
        end
      endcase
    end
  end

  // Request strobes decode straight from the state register so that reset drops
  // dmem_req and raises imem_req without waiting for a clock edge.
  assign imem_req = (state_reg == STAGE_FETCH);
  assign dmem_req = (state_reg == STAGE_MEMORY) && mem_access_reg;
  assign stage    = state_reg;
  assign pc       = pc_reg;
  assign instr    = instr_reg;
  assign fault    = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: walks the normal pipeline, memory waits,
// timeouts, halt, misalignment trap and asynchronous reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        mem_access;
  logic        halt_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_ack;
  logic [31:0] pc;
  logic [2:0]  stage;
  logic        imem_req;
  logic        dmem_req;
  logic [31:0] instr;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_sequencer #(
    .RESET_PC     (32'h0000_0100),
    .FETCH_TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_next   (pc_next),
    .pc_en     (pc_en),
    .mem_access(mem_access),
    .halt_req  (halt_req),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_ack  (dmem_ack),
    .pc        (pc),
    .stage     (stage),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .instr     (instr),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_next = '0; pc_en = 1'b0; mem_access = 1'b0; halt_req = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0;
    #2;
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_pc", pc, 32'h100);
    check("rst_imem_req", 32'(imem_req), 32'd1);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_instr", instr, 32'd0);
    step(); step();
    reset = 1'b0;

    // Minimum-latency instruction, no memory access
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013; pc_en = 1'b1; pc_next = 32'd4;
    step();
    check("t1_decode", 32'(stage), 32'd1);
    check("t1_instr", instr, 32'h13);
    check("t1_imem_drop", 32'(imem_req), 32'd0);
    check("t1_pc_ignored", pc, 32'h100);
    imem_ack = 1'b0;
    step(); check("t1_execute", 32'(stage), 32'd2);
    step(); check("t1_memory", 32'(stage), 32'd3);
    check("t1_no_dmem", 32'(dmem_req), 32'd0);
    step(); check("t1_regupd", 32'(stage), 32'd4);
    check("t1_pc_before", pc, 32'h100);
    step(); check("t1_fetch", 32'(stage), 32'd0);
    check("t1_pc", pc, 32'd4);
    check("t1_imem_req", 32'(imem_req), 32'd1);

    // Memory access acked on the fourth MEMORY cycle
    pc_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0023;
    step(); check("t2_decode", 32'(stage), 32'd1);
    check("t2_instr", instr, 32'h23);
    imem_ack = 1'b0; dmem_ack = 1'b1; mem_access = 1'b1;
    step(); check("t2_execute", 32'(stage), 32'd2);
    dmem_ack = 1'b0;
    step(); check("t2_mem_enter", 32'(stage), 32'd3);
    check("t2_dmem_req1", 32'(dmem_req), 32'd1);
    mem_access = 1'b0;
    step(); step(); step();
    check("t2_mem_cycle4", 32'(stage), 32'd3);
    check("t2_dmem_req4", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; pc_en = 1'b1; pc_next = 32'd8;
    step(); check("t2_regupd", 32'(stage), 32'd4);
    check("t2_dmem_drop", 32'(dmem_req), 32'd0);
    check("t2_pc_hold_mem", pc, 32'd4);
    dmem_ack = 1'b0;
    step(); check("t2_fetch", 32'(stage), 32'd0);
    check("t2_pc", pc, 32'd8);

    // imem_ack on the last permitted wait cycle still proceeds
    pc_en = 1'b0;
    repeat (15) step();
    check("t3_wait15_stage", 32'(stage), 32'd0);
    check("t3_wait15_fault", 32'(fault), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    step(); check("t3_late_ack", 32'(stage), 32'd1);
    check("t3_instr", instr, 32'h33);
    imem_ack = 1'b0;
    step(); step(); step();
    check("t3_regupd", 32'(stage), 32'd4);
    step(); check("t3_fetch", 32'(stage), 32'd0);
    check("t3_pc_hold", pc, 32'd8);

    // Halt requested in EXECUTE, released ten cycles later
    imem_ack = 1'b1; imem_rdata = 32'h0000_0043;
    step(); imem_ack = 1'b0;
    step(); check("t4_execute", 32'(stage), 32'd2);
    halt_req = 1'b1;
    step(); step();
    pc_en = 1'b1; pc_next = 32'h0000_000C;
    step(); check("t4_halted", 32'(stage), 32'd5);
    check("t4_pc", pc, 32'hC);
    check("t4_no_imem", 32'(imem_req), 32'd0);
    pc_next = 32'h0000_0010; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (6) step();
    check("t4_still_halted", 32'(stage), 32'd5);
    check("t4_pc_once", pc, 32'hC);
    check("t4_instr_hold", instr, 32'h43);
    halt_req = 1'b0; imem_ack = 1'b0; pc_en = 1'b0;
    step(); check("t4_resume", 32'(stage), 32'd0);
    check("t4_pc_after", pc, 32'hC);

    // Misaligned target with a simultaneous halt: trap wins
    imem_ack = 1'b1; imem_rdata = 32'h0000_0053;
    step(); imem_ack = 1'b0;
    step(); step();
    halt_req = 1'b1; pc_en = 1'b1; pc_next = 32'h0000_0102;
    step(); check("t5_regupd", 32'(stage), 32'd4);
    step(); check("t5_trap", 32'(stage), 32'd6);
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_pc_unchanged", pc, 32'hC);
    check("t5_no_imem", 32'(imem_req), 32'd0);
    halt_req = 1'b0; pc_next = 32'h0000_0020; imem_ack = 1'b1;
    repeat (3) step();
    check("t5_trap_held", 32'(stage), 32'd6);
    check("t5_pc_held", pc, 32'hC);
    check("t5_fault_sticky", 32'(fault), 32'd1);
    imem_ack = 1'b0; pc_en = 1'b0;

    // Asynchronous reset out of TRAP
    reset = 1'b1;
    #1;
    check("t5_async_stage", 32'(stage), 32'd0);
    check("t5_async_pc", pc, 32'h100);
    check("t5_async_fault", 32'(fault), 32'd0);
    check("t5_async_instr", instr, 32'd0);
    step();
    reset = 1'b0;

    // FETCH timeout with no ack at all
    repeat (16) step();
    check("t6_timeout_stage", 32'(stage), 32'd6);
    check("t6_timeout_fault", 32'(fault), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Reset during an outstanding data request, then a stale dmem_ack
    imem_ack = 1'b1; imem_rdata = 32'h0000_0063;
    step(); imem_ack = 1'b0; mem_access = 1'b1;
    step(); step(); mem_access = 1'b0;
    check("t7_dmem_req", 32'(dmem_req), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("t7_dmem_abort", 32'(dmem_req), 32'd0);
    check("t7_stage", 32'(stage), 32'd0);
    check("t7_pc", pc, 32'h100);
    dmem_ack = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("t7_stale_ack", 32'(stage), 32'd0);
    check("t7_instr", instr, 32'd0);
    dmem_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
